// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- 32-bit registered arithmetic/logic unit
//
// Takes two operands and an opcode from decode. One clock later it presents
// the result and status flags to writeback/branch logic. A new operation is
// accepted every cycle. There is no valid/ready handshake and no stall: what
// is on the inputs at a rising edge is what gets captured.
//
// Ports:
//   clk       in   1   rising-edge clock
//   reset     in   1   asynchronous, active-high; clears every output
//   operand1  in  32   operand A
//   operand2  in  32   operand B (shifts use B[4:0] as the amount)
//   opCode    in   6   operation select
//   result    out 32   registered result
//   zero      out  1   registered, result == 0
//   negative  out  1   registered, result[31]
//   carry     out  1   registered, ADD carry-out / SUB borrow, else 0
//   overflow  out  1   registered, signed overflow on ADD/SUB, else 0
//   invalidOp out  1   registered, opcode outside the defined set
// ---------------------------------------------------------------------------
module alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic [5:0]  opCode,
    output logic [31:0] result,
    output logic        zero,
    output logic        negative,
    output logic        carry,
    output logic        overflow,
    output logic        invalidOp
);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_XOR   = 6'b000100;
    localparam logic [5:0] OP_NOR   = 6'b000101;
    localparam logic [5:0] OP_SLL   = 6'b000110;
    localparam logic [5:0] OP_SRL   = 6'b000111;
    localparam logic [5:0] OP_SRA   = 6'b001000;
    localparam logic [5:0] OP_SLT   = 6'b001001;
    localparam logic [5:0] OP_SLTU  = 6'b001010;
    localparam logic [5:0] OP_PASSB = 6'b001011;

    // 33-bit add/subtract: bit 32 of the sum is the carry-out, bit 32 of the
    // difference is the borrow (set exactly when A < B unsigned).
    logic [32:0] sum;
    logic [32:0] diff;
    logic [4:0]  shamt;

    logic [31:0] res_d;
    logic        carry_d;
    logic        overflow_d;
    logic        invalid_d;

    assign sum   = {1'b0, operand1} + {1'b0, operand2};
    assign diff  = {1'b0, operand1} - {1'b0, operand2};
    assign shamt = operand2[4:0];

    always_comb begin
        res_d      = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        invalid_d  = 1'b0;
        case (opCode)
            OP_ADD: begin
                res_d      = sum[31:0];
                carry_d    = sum[32];
                overflow_d = (operand1[31] == operand2[31]) && (sum[31] != operand1[31]);
            end
            OP_SUB: begin
                res_d      = diff[31:0];
                carry_d    = diff[32];
                overflow_d = (operand1[31] != operand2[31]) && (diff[31] != operand1[31]);
            end
            OP_AND:   res_d = operand1 & operand2;
            OP_OR:    res_d = operand1 | operand2;
            OP_XOR:   res_d = operand1 ^ operand2;
            OP_NOR:   res_d = ~(operand1 | operand2);
            OP_SLL:   res_d = operand1 << shamt;
            OP_SRL:   res_d = operand1 >> shamt;
            OP_SRA:   res_d = $unsigned($signed(operand1) >>> shamt);
            OP_SLT:   res_d = {31'b0, ($signed(operand1) < $signed(operand2))};
            OP_SLTU:  res_d = {31'b0, (operand1 < operand2)};
            OP_PASSB: res_d = operand2;
            default:  invalid_d = 1'b1;
        endcase
    end

    // zero/negative come from the final result for every opcode, including
    // invalid ones (result 0 -> zero 1). During reset zero is forced to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result    <= '0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            invalidOp <= 1'b0;
        end else begin
            result    <= res_d;
            zero      <= (res_d == 32'd0);
            negative  <= res_d[31];
            carry     <= carry_d;
            overflow  <= overflow_d;
            invalidOp <= invalid_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- directed, table-driven bench for alu.
// Output word compared everywhere: {result, zero, negative, carry, overflow,
// invalidOp} (37 bits).
// ---------------------------------------------------------------------------
module tb_alu;

    logic        clk;
    logic        reset;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [5:0]  opCode;
    logic [31:0] result;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;
    logic        invalidOp;

    int checks;
    int errors;

    logic [36:0] exp_q[$];

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
        logic        i;
    } vec_t;

    vec_t vecs[22];

    alu dut (
        .clk       (clk),
        .reset     (reset),
        .operand1  (operand1),
        .operand2  (operand2),
        .opCode    (opCode),
        .result    (result),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow),
        .invalidOp (invalidOp)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        opCode   = op;
        operand1 = a;
        operand2 = b;
    endtask

    task automatic push_exp(input logic [31:0] r, input logic z, input logic n,
                            input logic c, input logic v, input logic i);
        exp_q.push_back({r, z, n, c, v, i});
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_out(input string name);
        logic [36:0] got;
        logic [36:0] exp;
        got = {result, zero, negative, carry, overflow, invalidOp};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: expected queue empty, got %h", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got result=%h z%0b n%0b c%0b v%0b i%0b, expected result=%h z%0b n%0b c%0b v%0b i%0b",
                         name, got[36:5], got[4], got[3], got[2], got[1], got[0],
                         exp[36:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //           name          op        A             B             R             z     n     c     v     i
        vecs[0]  = '{"add_2_3",    6'b000000, 32'd2,        32'd3,        32'd5,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{"sub_2_3",    6'b000001, 32'd2,        32'd3,        32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{"and_2_3",    6'b000010, 32'd2,        32'd3,        32'd2,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{"or_2_3",     6'b000011, 32'd2,        32'd3,        32'd3,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{"xor_2_3",    6'b000100, 32'd2,        32'd3,        32'd1,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"add_ovf",    6'b000000, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{"add_carry",  6'b000000, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{"sub_ovf",    6'b000001, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{"sll_4",      6'b000110, 32'h80000010, 32'd4,        32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{"srl_4",      6'b000111, 32'h80000010, 32'd4,        32'h08000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{"sra_4",      6'b001000, 32'h80000010, 32'd4,        32'hF8000001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{"slt",        6'b001001, 32'h80000010, 32'd1,        32'd1,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{"sltu",       6'b001010, 32'h80000010, 32'd1,        32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{"invalid_3f", 6'b111111, 32'd5,        32'd7,        32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{"nor",        6'b000101, 32'd0,        32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{"passb",      6'b001011, 32'd0,        32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        // shift amount uses only B[4:0]: 0x20 -> shift 0, 0xFFFFFFE4 -> shift 4
        vecs[16] = '{"sll_0",      6'b000110, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{"sra_b_hi",   6'b001000, 32'h80000010, 32'hFFFFFFE4, 32'hF8000001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{"invalid_0c", 6'b001100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{"sub_eq",     6'b000001, 32'd5,        32'd5,        32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{"slt_pos",    6'b001001, 32'd1,        32'h80000010, 32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[21] = '{"sltu_lt",    6'b001010, 32'd1,        32'h80000010, 32'd1,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset applied at time 0: outputs clear with no clock, zero reads 0.
        reset = 1'b1;
        drive(6'b000000, 32'd2, 32'd3);
        #1;
        push_exp(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_out("reset_initial");
        @(posedge clk);
        #1;
        push_exp(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_out("reset_held_edge");
        @(negedge clk);
        reset = 1'b0;

        // Table: one op per cycle, driven on negedge, checked 1 after posedge.
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            drive(vecs[k].op, vecs[k].a, vecs[k].b);
            push_exp(vecs[k].r, vecs[k].z, vecs[k].n, vecs[k].c, vecs[k].v, vecs[k].i);
            @(posedge clk);
            #1;
            check_out(vecs[k].name);
        end

        // Latency: output holds previous value until the edge that captures.
        @(negedge clk);
        drive(6'b000000, 32'd2, 32'd3);
        #1;
        push_exp(32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_out("latency_before_edge");
        @(posedge clk);
        #1;
        push_exp(32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_out("latency_after_edge");

        // Mid-stream asynchronous reset between edges while result=5.
        #2;
        drive(6'b000001, 32'd2, 32'd3);
        reset = 1'b1;
        #1;
        push_exp(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_out("async_reset_mid");
        @(posedge clk);
        #1;
        push_exp(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_out("reset_held_mid");
        #2;
        reset = 1'b0;
        #1;
        push_exp(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_out("deassert_before_edge");
        @(posedge clk);
        #1;
        push_exp(32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_out("first_capture_after_reset");

        // Inputs changing within a cycle: only the value at the edge counts.
        @(negedge clk);
        drive(6'b000100, 32'hAAAAAAAA, 32'h55555555);
        #2;
        drive(6'b000000, 32'd7, 32'd8);
        push_exp(32'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_out("late_input_change");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety bound in case the clocking above ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

endmodule
